modexp_unit: RTL
================

# modexp_unit

Parametrised successor to the fixed-width RSA core. Computes C = P^E mod M with right-to-left binary exponentiation on two bit-serial radix-2 Montgomery multipliers (multiply and square) running in parallel. Exponent width is independent of operand width. The block adds a start/busy/done handshake, operand latching, early termination after the highest set exponent bit, abort, and even-modulus error detection. It sits behind the RSA peripheral register file.

## Interface

Parameters:
- WIDTH, 8: operand and modulus width. Internal Montgomery width N = WIDTH+2, R = 2^N.
- EXP_WIDTH, WIDTH: exponent width, ≥1.

Ports:
- clk  in  1  clock. One clock domain.
- rst  in  1  reset, synchronous, active-high.
- ena  in  1  clock enable. When low, all state and outputs hold.
- clear  in  1  synchronous abort to IDLE. No done pulse. C and err hold.
- start  in  1  request. Sampled only in IDLE with ena high.
- P  in  WIDTH  base. Any value; P ≥ M is allowed.
- E  in  EXP_WIDTH  exponent.
- M  in  WIDTH  modulus. Must be odd.
- Const  in  WIDTH  R^2 mod M, supplied by software.
- C  out  WIDTH  result. Holds until the next successful completion.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  set on even modulus, cleared on the next accepted start.

## Operation

- On start in IDLE: latch P, E, M and Const into internal registers. Later input changes have no effect. Clear err.
- If latched M[0] == 0: go to ERR, then IDLE. C is forced to 0 and err is set.
- MM(A,B) is a bit-serial Montgomery product. Set T = 0, then for i = 0..N-1: s = T + A[i]*B; T = (s + s[0]*M) >> 1. One iteration per cycle, N cycles per product. Both multipliers share one iteration counter. Internal datapath is N+1 bits; no intermediate subtraction is done (outputs < 2M).
- States and their work:
  - IDLE.
  - PRE, N cycles: X = MM(Const, P) and Y = MM(Const, 1) in parallel.
  - EXP, N cycles per exponent bit, processed LSB first: X = MM(X, X) always. Y = MM(Y, X) only if the current bit is 1; otherwise Y holds and that multiplier idles.
  - POST, N cycles: Y = MM(Y, 1).
  - FIX, 1 cycle: C = (Y ≥ M) ? Y−M : Y.
  - ERR, 1 cycle.
- Early termination: after each EXP product, shift the exponent register right. If the remaining value is 0, go to POST. If latched E == 0, go PRE → POST directly, which gives C = 1 mod M.
- Transitions:
  - IDLE → PRE, or → ERR on even M.
  - PRE → EXP, or → POST if E == 0.
  - EXP → EXP, or → POST when remaining exponent is 0.
  - POST → FIX → IDLE.
  - ERR → IDLE.
- start while busy is ignored; it is not queued.
- rst and clear both have priority over start in the same cycle. rst also has priority over ena.

## Timing

- Reset values: C = 0, busy = 0, done = 0, err = 0, state IDLE.
- Let start be sampled at edge t0, and let k = index of the highest set bit of E plus 1 (k = 0 for E = 0).
- busy rises after t0.
- Normal completion: done = 1, busy = 0, and the new C is visible in the cycle after edge t0 + N·(k+2) + 1. The latency is L = N·(k+2) + 2 cycles from start. For WIDTH = 8, L = 10k + 22.
- Error completion: done = 1, err = 1 and C = 0 in the cycle after edge t0 + 1.
- done is high for exactly one cycle. C and err are stable from that cycle until the next completion.
- ena low stretches every count by the number of disabled cycles; done is never lost.
- A new start is accepted in the cycle done is high (busy is already 0).
- clear mid-operation: busy falls the next cycle and no done is issued. The next start behaves as if from reset, apart from the retained C and err.

## Test plan

- WIDTH=8, M=187, Const=67, P=88, E=7 → C=11, done exactly 52 cycles after start, err=0.
- M=187, Const=67, P=11, E=23 → C=88, L=72; then E=0, P=88 → C=1, L=22.
- M=255, Const=16, P=254, E=255 → C=254, L=102; inputs changed during busy do not alter the result.
- M=186 (even), P=5, E=3 → err=1, C=0, done one cycle after start; next valid start clears err.
- Start P=88, E=7, M=187; assert clear at cycle 20 → no done, busy low at cycle 21, C unchanged. Immediate restart → C=11 at L=52. start pulses during busy are ignored.
- ena toggled 50% during P=88, E=7 → C=11 with latency 52 enabled cycles. rst asserted mid-EXP → all outputs 0 the next cycle.

Source files
------------

// File: rtl/modexp_unit.sv
// Modular exponentiation C = P^E mod M using two bit-serial radix-2 Montgomery
// multipliers (square and multiply) with right-to-left binary exponentiation.
`timescale 1ns/1ps
module modexp_unit #(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 clear,
    input  logic                 start,
    input  logic [WIDTH-1:0]     P,
    input  logic [EXP_WIDTH-1:0] E,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Const,
    output logic [WIDTH-1:0]     C,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int N  = WIDTH + 2;
    localparam int CW = $clog2(N);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_EXP, S_POST, S_FIX, S_ERR} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_nxt;
    logic [EXP_WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0]     p_q, p_d, m_q, m_d, k_q, k_d, c_q, c_d;
    logic [N-1:0]         x_q, x_d, y_q, y_d, tx_q, tx_d, ty_q, ty_d;
    logic                 done_q, done_d, err_q, err_d;
    logic [N-1:0]         ax, bx, ay, by, tx_n, ty_n;
    logic                 y_en, last;

    // One Montgomery iteration; operands stay below 2M so N+1 bits never overflow.
    function automatic logic [N-1:0] mm_step(input logic [N-1:0] t, input logic a,
                                             input logic [N-1:0] b, input logic [WIDTH-1:0] m);
        logic [N:0] s;
        s = {1'b0, t} + (a ? {1'b0, b} : '0);
        s = s + (s[0] ? (N+1)'(m) : '0);
        return s[N:1];
    endfunction

    always_comb begin
        ax   = N'(k_q);
        bx   = N'(p_q);
        ay   = N'(k_q);
        by   = N'(1);
        y_en = 1'b1;
        case (state_q)
            S_EXP: begin
                ax   = x_q;
                bx   = x_q;
                ay   = y_q;
                by   = x_q;
                y_en = e_q[0];
            end
            S_POST: begin
                ay = y_q;
                by = N'(1);
            end
            default: ;
        endcase
        tx_n = mm_step(tx_q, ax[cnt_q], bx, m_q);
        ty_n = mm_step(ty_q, ay[cnt_q], by, m_q);
    end

    assign last    = (cnt_q == CW'(N - 1));
    assign cnt_nxt = last ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        p_d     = p_q;
        m_d     = m_q;
        k_d     = k_q;
        c_d     = c_q;
        x_d     = x_q;
        y_d     = y_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    p_d     = P;
                    e_d     = E;
                    m_d     = M;
                    k_d     = Const;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    tx_d    = '0;
                    ty_d    = '0;
                    state_d = M[0] ? S_PRE : S_ERR;
                end
            end
            S_PRE: begin
                cnt_d = cnt_nxt;
                tx_d  = last ? '0 : tx_n;
                ty_d  = last ? '0 : ty_n;
                if (last) begin
                    x_d     = tx_n;
                    y_d     = ty_n;
                    state_d = (e_q == '0) ? S_POST : S_EXP;
                end
            end
            S_EXP: begin
                cnt_d = cnt_nxt;
                tx_d  = last ? '0 : tx_n;
                if (y_en) ty_d = last ? '0 : ty_n;
                if (last) begin
                    x_d = tx_n;
                    if (y_en) y_d = ty_n;
                    // Stop as soon as no set exponent bits remain.
                    e_d     = e_q >> 1;
                    state_d = ((e_q >> 1) == '0) ? S_POST : S_EXP;
                end
            end
            S_POST: begin
                cnt_d = cnt_nxt;
                ty_d  = last ? '0 : ty_n;
                if (last) begin
                    y_d     = ty_n;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                c_d     = (y_q >= N'(m_q)) ? WIDTH'(y_q - N'(m_q)) : y_q[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                c_d     = '0;
                err_d   = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            c_d     = c_q;
            err_d   = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            c_q     <= '0;
        end else if (ena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            c_q     <= c_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ena) begin
            e_q  <= e_d;
            p_q  <= p_d;
            m_q  <= m_d;
            k_q  <= k_d;
            x_q  <= x_d;
            y_q  <= y_d;
            tx_q <= tx_d;
            ty_q <= ty_d;
        end
    end

    assign C    = c_q;
    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign err  = err_q;
endmodule
